// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/halfword lane extraction for loads and lane merge for sub-word stores
module lsu_align import lsu_pkg::*; (
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [4:0]  sh;
   logic [31:0] lane;
   logic [31:0] mask;
   // shift the addressed lane down for loads; splice store data into the old word for SB/SH
   always_comb begin
      sh = {off, 3'b000};
      lane = word >> sh;
      load_data = funct3 == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                  funct3 == F3_BU ? {24'h0, lane[7:0]} :
                  funct3 == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                  funct3 == F3_HU ? {16'h0, lane[15:0]} : word;
      mask = (funct3 == F3_B ? 32'h0000_00ff : funct3 == F3_H ? 32'h0000_ffff : 32'hffff_ffff) << sh;
      store_word = (word & ~mask) | ((wdata << sh) & mask);
   end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding RV32I load/store initiator for a word-only data memory
module lsu_mem_master import lsu_pkg::*; #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);
   lsu_state_t  state;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic        legal;
   logic        misaligned;
   logic        err;
   logic        sw;
   logic [31:0] load_data;
   logic [31:0] store_word;

   lsu_align u_align (
      .funct3     (funct3_q),
      .off        (off_q),
      .word       (mem_read_data),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // handshakes and memory strobes decode straight from state; request checks run on the live inputs
   always_comb begin
      req_ready  = state == IDLE;
      resp_valid = state == RESP;
      mem_read   = state == RD;
      mem_write  = state == WR;
      legal = req_we ? (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W)
                     : (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                        req_funct3 == F3_BU || req_funct3 == F3_HU);
      misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      err = !legal || misaligned || {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
      sw  = req_we && req_funct3 == F3_W;
   end

   // request capture, read/merge/write sequencing and response holding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         funct3_q       <= 3'b000;
         off_q          <= 2'b00;
         wdata_q        <= 32'h0;
         we_q           <= 1'b0;
         resp_rdata     <= 32'h0;
         resp_err       <= 1'b0;
         mem_address    <= 32'h0;
         mem_write_data <= 32'h0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               funct3_q   <= req_funct3;
               off_q      <= req_addr[1:0];
               wdata_q    <= req_wdata;
               we_q       <= req_we;
               resp_rdata <= 32'h0;
               resp_err   <= err;
               if (!err) mem_address <= {2'b00, req_addr[31:2]};
               if (!err && sw) mem_write_data <= req_wdata;
               state <= err ? RESP : sw ? WR : RD;
            end
            RD: begin
               if (we_q) mem_write_data <= store_word;
               else resp_rdata <= load_data;
               state <= we_q ? WR : RESP;
            end
            WR: state <= RESP;
            RESP: if (resp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: lsu_mem_master against a word memory and a byte-level reference model
module tb_lsu_mem_master;
   import lsu_pkg::*;
   logic clk = 1'b0, rst = 1'b1, init = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
   logic [2:0] req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic req_ready, resp_valid, resp_err, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
   logic [31:0] mem [1024];
   logic [31:0] ref_mem [1024];
   int errors = 0, checks = 0;

   typedef struct {logic we; logic [2:0] f3; logic [31:0] a, wd, exp; logic ee; int lat;} vec_t;

   lsu_mem_master #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
      .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address[9:0]];
   always @(posedge clk) begin
      if (init) for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
      else if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
   end

   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int nr, output int nw);
      int size, idx, bo;
      logic legal;
      logic [31:0] w, v;
      size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      er = !legal || (a % size != 0) || (a / 4 >= 1024);
      rd = 32'h0; lat = 1; nr = 0; nw = 0;
      if (!er) begin
         idx = int'(a / 4); bo = int'(a % 4); w = ref_mem[idx];
         if (we) begin
            for (int k = 0; k < size; k++) w[8*(bo+k) +: 8] = wd[8*k +: 8];
            ref_mem[idx] = w;
            lat = size == 4 ? 2 : 3; nr = size == 4 ? 0 : 1; nw = 1;
         end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = w[8*(bo+k) +: 8];
            if (!f3[2] && size < 4 && v[8*size-1]) for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hff;
            rd = v; lat = 2; nr = 1;
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output int nr, output int nw,
                         output int rd_at, output int wr_at, output logic clash);
      rd = 32'h0; er = 1'b0; lat = 99; nr = 0; nw = 0; rd_at = 0; wr_at = 0; clash = 1'b0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (mem_read) begin nr++; rd_at = n; end
         if (mem_write) begin nw++; wr_at = n; end
         if (mem_read && mem_write) clash = 1'b1;
         if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
      checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b want=00", {mem_read, mem_write}); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
      checks++; if ({mem_address, mem_write_data} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", mem_address, mem_write_data); end
   endtask

   task automatic test_load_store();
      vec_t v [8];
      logic [31:0] rd, mrd;
      logic er, mer, clash;
      int lat, nr, nw, rd_at, wr_at, mlat, mnr, mnw;
      v[0] = '{1'b0, F3_W,  32'h14, 32'h0,    32'h0000_0005, 1'b0, 2};
      v[1] = '{1'b1, F3_B,  32'h15, 32'hff,   32'h0,         1'b0, 3};
      v[2] = '{1'b0, F3_W,  32'h14, 32'h0,    32'h0000_ff05, 1'b0, 2};
      v[3] = '{1'b0, F3_B,  32'h15, 32'h0,    32'hffff_ffff, 1'b0, 2};
      v[4] = '{1'b0, F3_BU, 32'h15, 32'h0,    32'h0000_00ff, 1'b0, 2};
      v[5] = '{1'b1, F3_H,  32'h22, 32'h8765, 32'h0,         1'b0, 3};
      v[6] = '{1'b0, F3_W,  32'h20, 32'h0,    32'h8765_0008, 1'b0, 2};
      v[7] = '{1'b0, F3_HU, 32'h22, 32'h0,    32'h0000_8765, 1'b0, 2};
      for (int i = 0; i < 8; i++) begin
         model(v[i].we, v[i].f3, v[i].a, v[i].wd, mrd, mer, mlat, mnr, mnw);
         do_req(v[i].we, v[i].f3, v[i].a, v[i].wd, rd, er, lat, nr, nw, rd_at, wr_at, clash);
         checks++; if (rd !== v[i].exp) begin errors++; $display("FAIL ls%0d_rdata got=%h want=%h", i, rd, v[i].exp); end
         checks++; if (er !== v[i].ee) begin errors++; $display("FAIL ls%0d_err got=%b want=%b", i, er, v[i].ee); end
         checks++; if (lat != v[i].lat) begin errors++; $display("FAIL ls%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
         checks++; if (nr != mnr || nw != mnw) begin errors++; $display("FAIL ls%0d_strobe_count got=%0d/%0d want=%0d/%0d", i, nr, nw, mnr, mnw); end
         checks++; if (rd_at != (mnr > 0 ? 1 : 0) || wr_at != (mnw > 0 ? v[i].lat - 1 : 0)) begin errors++; $display("FAIL ls%0d_strobe_cycle got=%0d/%0d", i, rd_at, wr_at); end
         checks++; if (clash !== 1'b0) begin errors++; $display("FAIL ls%0d_rd_wr_overlap got=1 want=0", i); end
      end
   endtask

   task automatic test_errors();
      vec_t v [5];
      logic [31:0] rd, mrd;
      logic er, mer, clash;
      int lat, nr, nw, rd_at, wr_at, mlat, mnr, mnw;
      v[0] = '{1'b0, F3_W,   32'h16,   32'h0,  32'h0, 1'b1, 1};
      v[1] = '{1'b1, F3_H,   32'h21,   32'h55, 32'h0, 1'b1, 1};
      v[2] = '{1'b0, F3_W,   32'h1000, 32'h0,  32'h0, 1'b1, 1};
      v[3] = '{1'b1, F3_BU,  32'h30,   32'h66, 32'h0, 1'b1, 1};
      v[4] = '{1'b0, 3'b011, 32'h0,    32'h0,  32'h0, 1'b1, 1};
      for (int i = 0; i < 5; i++) begin
         model(v[i].we, v[i].f3, v[i].a, v[i].wd, mrd, mer, mlat, mnr, mnw);
         do_req(v[i].we, v[i].f3, v[i].a, v[i].wd, rd, er, lat, nr, nw, rd_at, wr_at, clash);
         checks++; if (er !== v[i].ee) begin errors++; $display("FAIL err%0d_flag got=%b want=%b", i, er, v[i].ee); end
         checks++; if (rd !== v[i].exp) begin errors++; $display("FAIL err%0d_rdata got=%h want=%h", i, rd, v[i].exp); end
         checks++; if (lat != v[i].lat) begin errors++; $display("FAIL err%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
         checks++; if (nr != 0 || nw != 0) begin errors++; $display("FAIL err%0d_no_access got=%0d/%0d want=0/0", i, nr, nw); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] mrd;
      logic mer;
      int mlat, mnr, mnw, n;
      model(1'b0, F3_W, 32'h20, 32'h0, mrd, mer, mlat, mnr, mnw);
      resp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h20;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 3; i++) begin
         checks++; if (resp_valid !== 1'b1 || resp_rdata !== mrd) begin errors++; $display("FAIL bp_hold%0d got=%b/%h want=1/%h", i, resp_valid, resp_rdata, mrd); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready%0d got=%b want=0", i, req_ready); end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b/%b want=0/1", resp_valid, req_ready); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, mrd;
      logic er, mer, clash;
      int lat, nr, nw, rd_at, wr_at, mlat, mnr, mnw;
      for (int i = 0; i < 3; i++) begin
         model(1'b1, F3_W, 32'h40 + 32'(4*i), 32'hc0de_0000 + 32'(i), mrd, mer, mlat, mnr, mnw);
         do_req(1'b1, F3_W, 32'h40 + 32'(4*i), 32'hc0de_0000 + 32'(i), rd, er, lat, nr, nw, rd_at, wr_at, clash);
         checks++; if (lat != mlat || wr_at != 1) begin errors++; $display("FAIL b2b%0d_sw_timing got=%0d/%0d want=%0d/1", i, lat, wr_at, mlat); end
         checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b%0d_ready got=%b/%b want=1/0", i, req_ready, resp_valid); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, mrd, a, wd;
      logic er, mer, clash, we;
      logic [2:0] f3;
      int lat, nr, nw, rd_at, wr_at, mlat, mnr, mnw;
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 255));
         wd = $urandom;
         model(we, f3, a, wd, mrd, mer, mlat, mnr, mnw);
         do_req(we, f3, a, wd, rd, er, lat, nr, nw, rd_at, wr_at, clash);
         checks++; if (rd !== mrd) begin errors++; $display("FAIL rnd%0d_rdata we=%b f3=%0d a=%h got=%h want=%h", i, we, f3, a, rd, mrd); end
         checks++; if (er !== mer) begin errors++; $display("FAIL rnd%0d_err we=%b f3=%0d a=%h got=%b want=%b", i, we, f3, a, er, mer); end
         checks++; if (lat != mlat) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, mlat); end
         checks++; if (nr != mnr || nw != mnw || clash) begin errors++; $display("FAIL rnd%0d_strobes got=%0d/%0d/%b want=%0d/%0d/0", i, nr, nw, clash, mnr, mnw); end
      end
   endtask

   task automatic test_rst_mid();
      logic [31:0] rd, mrd;
      logic er, mer, clash;
      int lat, nr, nw, rd_at, wr_at, mlat, mnr, mnw, n;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h80; req_wdata = 32'haa;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_write && n < 10) begin @(negedge clk); n++; end
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_reach_wr got=%b want=1", mem_write); end
      #1 rst = 1'b1;
      #1;
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_async_wr_drop got=%b want=0", mem_write); end
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b/%b want=1/0", req_ready, resp_valid); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resp got=%b want=0", resp_valid); end
      model(1'b0, F3_W, 32'h80, 32'h0, mrd, mer, mlat, mnr, mnw);
      do_req(1'b0, F3_W, 32'h80, 32'h0, rd, er, lat, nr, nw, rd_at, wr_at, clash);
      checks++; if (rd !== mrd || er !== 1'b0) begin errors++; $display("FAIL rst_abandoned_store got=%h want=%h", rd, mrd); end
   endtask

   task automatic test_memory_image();
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL memory_image got=%0d differing words want=0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);
      repeat (3) @(negedge clk);
      init = 1'b0;
      rst = 1'b0;
      test_reset();
      test_load_store();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_rst_mid();
      test_memory_image();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
